// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with bypass, NZP condition codes and pending-load scoreboard
module regfile_scoreboard #(
   parameter int WIDTH    = 16,
   parameter int NREGS    = 8,
   parameter int LINK_REG = 7,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic [AW-1:0]    i_src_a,
   input  logic [AW-1:0]    i_src_b,
   input  logic             i_rd_a_en,
   input  logic             i_rd_b_en,
   output logic [WIDTH-1:0] o_reg_a,
   output logic [WIDTH-1:0] o_reg_b,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_dest,
   input  logic             i_wr_link,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_load_cc,
   output logic [2:0]       o_cc,
   input  logic [2:0]       i_br_nzp,
   output logic             o_branch_enable,
   input  logic             i_issue_en,
   input  logic [AW-1:0]    i_issue_dest,
   output logic             o_hazard,
   output logic [NREGS-1:0] o_scoreboard,
   output logic             o_issue_err
);

   localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);

   logic [WIDTH-1:0] r_regs [NREGS];
   logic [2:0]       r_cc;
   logic [NREGS-1:0] r_sb;
   logic             r_err;

   logic [AW-1:0]    w_dst;
   logic             w_wr_hit;
   logic             w_iss_hit;
   logic             w_a_in, w_b_in;
   logic             w_a_byp, w_b_byp;
   logic             w_busy_a, w_busy_b;
   logic [NREGS-1:0] w_sb_next;

   assign w_dst     = i_wr_link ? LINK_IDX : i_wr_dest;
   assign w_wr_hit  = i_wr_en && (int'(w_dst) < NREGS);
   assign w_iss_hit = i_issue_en && (int'(i_issue_dest) < NREGS);

   // Out-of-range indices (non power-of-two NREGS) read as 0 and are never busy.
   always_comb begin
      w_a_in  = int'(i_src_a) < NREGS;
      w_b_in  = int'(i_src_b) < NREGS;
      w_a_byp = (BYPASS != 0) && i_wr_en && (w_dst == i_src_a);
      w_b_byp = (BYPASS != 0) && i_wr_en && (w_dst == i_src_b);
      o_reg_a = '0;
      o_reg_b = '0;
      w_busy_a = 1'b0;
      w_busy_b = 1'b0;
      if (w_a_in) begin
         o_reg_a  = w_a_byp ? i_wr_data : r_regs[i_src_a];
         w_busy_a = r_sb[i_src_a] && !w_a_byp;
      end
      if (w_b_in) begin
         o_reg_b  = w_b_byp ? i_wr_data : r_regs[i_src_b];
         w_busy_b = r_sb[i_src_b] && !w_b_byp;
      end
   end

   // Issue is applied after writeback so a same-cycle set wins over the clear.
   always_comb begin
      w_sb_next = r_sb;
      if (w_wr_hit) begin
         w_sb_next[w_dst] = 1'b0;
      end
      if (w_iss_hit) begin
         w_sb_next[i_issue_dest] = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
         r_cc  <= 3'b010;
         r_sb  <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_wr_hit) begin
            r_regs[w_dst] <= i_wr_data;
         end
         if (i_load_cc) begin
            if (i_wr_data[WIDTH-1]) begin
               r_cc <= 3'b100;
            end else if (i_wr_data == '0) begin
               r_cc <= 3'b010;
            end else begin
               r_cc <= 3'b001;
            end
         end
         r_sb <= w_sb_next;
         if (w_iss_hit && r_sb[i_issue_dest] && !(w_wr_hit && (w_dst == i_issue_dest))) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_hazard        = (i_rd_a_en && w_busy_a) || (i_rd_b_en && w_busy_b);
   assign o_cc            = r_cc;
   assign o_branch_enable = |(i_br_nzp & r_cc);
   assign o_scoreboard    = r_sb;
   assign o_issue_err     = r_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - vector table, directed sequences and random model check for regfile_scoreboard
module tb_regfile_scoreboard;

   typedef struct {
      logic        rst_n;
      logic [2:0]  sa, sbi;
      logic        rda, rdb, we;
      logic [2:0]  wd;
      logic        wl;
      logic [15:0] wdata;
      logic        lcc;
      logic [2:0]  br;
      logic        ie;
      logic [2:0]  id;
      logic [15:0] e_ra;
      logic [2:0]  e_cc;
      logic        e_be, e_hz;
      logic [7:0]  e_sb;
      logic        e_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        t_rst_n, t_rda, t_rdb, t_we, t_wl, t_lcc, t_ie;
   logic [2:0]  t_sa, t_sb, t_wd, t_br, t_id;
   logic [15:0] t_wdata;

   logic [15:0] ra [3];
   logic [15:0] rb [3];
   logic [2:0]  cco [3];
   logic        be [3];
   logic        hz [3];
   logic        er [3];
   logic [7:0]  sb0, sb1;
   logic [5:0]  sb6;

   // Instances: 0 = defaults, 1 = no forwarding, 2 = six registers with link at R5.
   int nregs [3] = '{8, 8, 6};
   int link  [3] = '{7, 7, 5};
   int byp   [3] = '{1, 0, 1};

   logic [15:0] m_reg [3][8];
   logic [2:0]  m_cc  [3];
   logic        m_pend[3][8];
   logic        m_err [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_scoreboard u_b1 (
      .i_clk(clk), .i_reset_n(t_rst_n), .i_src_a(t_sa), .i_src_b(t_sb),
      .i_rd_a_en(t_rda), .i_rd_b_en(t_rdb), .o_reg_a(ra[0]), .o_reg_b(rb[0]),
      .i_wr_en(t_we), .i_wr_dest(t_wd), .i_wr_link(t_wl), .i_wr_data(t_wdata),
      .i_load_cc(t_lcc), .o_cc(cco[0]), .i_br_nzp(t_br), .o_branch_enable(be[0]),
      .i_issue_en(t_ie), .i_issue_dest(t_id), .o_hazard(hz[0]),
      .o_scoreboard(sb0), .o_issue_err(er[0])
   );

   regfile_scoreboard #(.BYPASS(0)) u_b0 (
      .i_clk(clk), .i_reset_n(t_rst_n), .i_src_a(t_sa), .i_src_b(t_sb),
      .i_rd_a_en(t_rda), .i_rd_b_en(t_rdb), .o_reg_a(ra[1]), .o_reg_b(rb[1]),
      .i_wr_en(t_we), .i_wr_dest(t_wd), .i_wr_link(t_wl), .i_wr_data(t_wdata),
      .i_load_cc(t_lcc), .o_cc(cco[1]), .i_br_nzp(t_br), .o_branch_enable(be[1]),
      .i_issue_en(t_ie), .i_issue_dest(t_id), .o_hazard(hz[1]),
      .o_scoreboard(sb1), .o_issue_err(er[1])
   );

   regfile_scoreboard #(.NREGS(6), .LINK_REG(5)) u_n6 (
      .i_clk(clk), .i_reset_n(t_rst_n), .i_src_a(t_sa), .i_src_b(t_sb),
      .i_rd_a_en(t_rda), .i_rd_b_en(t_rdb), .o_reg_a(ra[2]), .o_reg_b(rb[2]),
      .i_wr_en(t_we), .i_wr_dest(t_wd), .i_wr_link(t_wl), .i_wr_data(t_wdata),
      .i_load_cc(t_lcc), .o_cc(cco[2]), .i_br_nzp(t_br), .o_branch_enable(be[2]),
      .i_issue_en(t_ie), .i_issue_dest(t_id), .o_hazard(hz[2]),
      .o_scoreboard(sb6), .o_issue_err(er[2])
   );

   function automatic logic [7:0] dut_sb(int k);
      if (k == 0) return sb0;
      if (k == 1) return sb1;
      return {2'b00, sb6};
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst=%0d t=%0t actual=%h expected=%h", name, k, $time, act, exp);
      end
   endtask

   function automatic int dst_of(int k);
      return t_wl ? link[k] : int'(t_wd);
   endfunction

   function automatic logic [15:0] m_read(int k, int s);
      if (s >= nregs[k]) return 16'h0;
      if (byp[k] != 0 && t_we && dst_of(k) == s) return t_wdata;
      return m_reg[k][s];
   endfunction

   function automatic logic m_busy(int k, int s);
      if (s >= nregs[k]) return 1'b0;
      return m_pend[k][s] && !(byp[k] != 0 && t_we && dst_of(k) == s);
   endfunction

   function automatic logic [7:0] m_sbvec(int k);
      logic [7:0] v = 8'h00;
      for (int i = 0; i < nregs[k]; i++) v[i] = m_pend[k][i];
      return v;
   endfunction

   task automatic model_check();
      for (int k = 0; k < 3; k++) begin
         chk("reg_a", k, 32'(ra[k]), 32'(m_read(k, int'(t_sa))));
         chk("reg_b", k, 32'(rb[k]), 32'(m_read(k, int'(t_sb))));
         chk("cc", k, 32'(cco[k]), 32'(m_cc[k]));
         chk("branch_enable", k, 32'(be[k]), 32'((t_br & m_cc[k]) != 3'b000));
         chk("hazard", k, 32'(hz[k]),
             32'((t_rda && m_busy(k, int'(t_sa))) || (t_rdb && m_busy(k, int'(t_sb)))));
         chk("scoreboard", k, 32'(dut_sb(k)), 32'(m_sbvec(k)));
         chk("issue_err", k, 32'(er[k]), 32'(m_err[k]));
      end
   endtask

   task automatic model_update();
      for (int k = 0; k < 3; k++) begin
         if (!t_rst_n) begin
            for (int i = 0; i < 8; i++) begin
               m_reg[k][i]  = 16'h0;
               m_pend[k][i] = 1'b0;
            end
            m_cc[k]  = 3'b010;
            m_err[k] = 1'b0;
         end else begin
            int  d   = dst_of(k);
            int  isd = int'(t_id);
            bit  wr  = t_we && d < nregs[k];
            bit  iss = t_ie && isd < nregs[k];
            if (iss && m_pend[k][isd] && !(wr && d == isd)) m_err[k] = 1'b1;
            if (wr) begin
               m_reg[k][d]  = t_wdata;
               m_pend[k][d] = 1'b0;
            end
            if (iss) m_pend[k][isd] = 1'b1;
            if (t_lcc) begin
               if ($signed(t_wdata) < 0) m_cc[k] = 3'b100;
               else if (t_wdata == 16'h0) m_cc[k] = 3'b010;
               else m_cc[k] = 3'b001;
            end
         end
      end
   endtask

   task automatic idle();
      t_rst_n = 1'b1; t_sa = 0; t_sb = 0; t_rda = 0; t_rdb = 0;
      t_we = 0; t_wd = 0; t_wl = 0; t_wdata = 16'h0; t_lcc = 0;
      t_br = 0; t_ie = 0; t_id = 0;
   endtask

   task automatic settle();
      #4;
      model_check();
   endtask

   task automatic edge_step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   function automatic vec_t mk(logic rst_n, logic [2:0] sa, logic [2:0] sbi, logic rda, logic rdb,
                               logic we, logic [2:0] wd, logic wl, logic [15:0] wdata, logic lcc,
                               logic [2:0] br, logic ie, logic [2:0] id, logic [15:0] e_ra,
                               logic [2:0] e_cc, logic e_be, logic e_hz, logic [7:0] e_sb, logic e_err);
      vec_t v;
      v.rst_n = rst_n; v.sa = sa; v.sbi = sbi; v.rda = rda; v.rdb = rdb; v.we = we; v.wd = wd;
      v.wl = wl; v.wdata = wdata; v.lcc = lcc; v.br = br; v.ie = ie; v.id = id;
      v.e_ra = e_ra; v.e_cc = e_cc; v.e_be = e_be; v.e_hz = e_hz; v.e_sb = e_sb; v.e_err = e_err;
      return v;
   endfunction

   vec_t tbl [$];

   initial begin
      // Expected values are the pre-edge outputs of the default instance in that cycle.
      tbl.push_back(mk(1,0,0,0,0, 0,0,0,16'h0000,0, 3'b010,0,0, 16'h0000,3'b010,1,0,8'h00,0));
      tbl.push_back(mk(1,3,0,0,0, 1,3,0,16'h8001,1, 3'b011,0,0, 16'h8001,3'b010,1,0,8'h00,0));
      tbl.push_back(mk(1,3,0,0,0, 0,0,0,16'h0000,0, 3'b011,0,0, 16'h8001,3'b100,0,0,8'h00,0));
      tbl.push_back(mk(1,3,0,0,0, 1,0,0,16'h0000,1, 3'b100,0,0, 16'h8001,3'b100,1,0,8'h00,0));
      tbl.push_back(mk(1,1,0,0,0, 1,1,0,16'h0005,1, 3'b111,0,0, 16'h0005,3'b010,1,0,8'h00,0));
      tbl.push_back(mk(1,1,0,0,0, 0,0,0,16'h0000,0, 3'b001,0,0, 16'h0005,3'b001,1,0,8'h00,0));
      tbl.push_back(mk(1,2,0,0,0, 1,2,0,16'h1234,0, 3'b000,0,0, 16'h1234,3'b001,0,0,8'h00,0));
      tbl.push_back(mk(1,7,0,0,0, 1,1,1,16'h3001,0, 3'b000,0,0, 16'h3001,3'b001,0,0,8'h00,0));
      tbl.push_back(mk(1,1,0,0,0, 0,0,0,16'h0000,0, 3'b000,0,0, 16'h0005,3'b001,0,0,8'h00,0));
      tbl.push_back(mk(1,7,0,0,0, 0,0,0,16'h0000,0, 3'b000,0,0, 16'h3001,3'b001,0,0,8'h00,0));
      tbl.push_back(mk(1,0,4,0,1, 0,0,0,16'h0000,0, 3'b000,1,4, 16'h0000,3'b001,0,0,8'h00,0));
      tbl.push_back(mk(1,0,4,0,1, 0,0,0,16'h0000,0, 3'b000,0,0, 16'h0000,3'b001,0,1,8'h10,0));
      tbl.push_back(mk(1,0,4,0,1, 0,0,0,16'h0000,0, 3'b000,0,0, 16'h0000,3'b001,0,1,8'h10,0));
      tbl.push_back(mk(1,4,4,0,1, 1,4,0,16'h00AA,0, 3'b000,0,0, 16'h00AA,3'b001,0,0,8'h10,0));
      tbl.push_back(mk(1,4,4,0,1, 0,0,0,16'h0000,0, 3'b000,0,0, 16'h00AA,3'b001,0,0,8'h00,0));
      tbl.push_back(mk(1,0,4,0,0, 0,0,0,16'h0000,0, 3'b000,1,4, 16'h0000,3'b001,0,0,8'h00,0));
      tbl.push_back(mk(1,0,4,0,0, 0,0,0,16'h0000,0, 3'b000,0,0, 16'h0000,3'b001,0,0,8'h10,0));
      tbl.push_back(mk(1,4,4,0,0, 1,4,0,16'h00BB,0, 3'b000,0,0, 16'h00BB,3'b001,0,0,8'h10,0));
      tbl.push_back(mk(1,5,0,0,0, 1,5,0,16'h0055,0, 3'b000,1,5, 16'h0055,3'b001,0,0,8'h00,0));
      tbl.push_back(mk(1,5,0,0,0, 0,0,0,16'h0000,0, 3'b000,1,5, 16'h0055,3'b001,0,0,8'h20,0));
      tbl.push_back(mk(1,5,0,0,0, 0,0,0,16'h0000,0, 3'b000,0,0, 16'h0055,3'b001,0,0,8'h20,1));
      tbl.push_back(mk(1,5,0,1,0, 0,0,0,16'h0000,0, 3'b000,0,0, 16'h0055,3'b001,0,1,8'h20,1));
      tbl.push_back(mk(0,0,0,0,0, 0,0,0,16'h0000,0, 3'b000,0,0, 16'h0000,3'b001,0,0,8'h20,1));
      tbl.push_back(mk(1,5,0,1,0, 0,0,0,16'h0000,0, 3'b010,0,0, 16'h0000,3'b010,1,0,8'h00,0));

      idle();
      t_rst_n = 1'b0;
      edge_step();
      edge_step();

      foreach (tbl[i]) begin
         t_rst_n = tbl[i].rst_n; t_sa = tbl[i].sa; t_sb = tbl[i].sbi; t_rda = tbl[i].rda;
         t_rdb = tbl[i].rdb; t_we = tbl[i].we; t_wd = tbl[i].wd; t_wl = tbl[i].wl;
         t_wdata = tbl[i].wdata; t_lcc = tbl[i].lcc; t_br = tbl[i].br; t_ie = tbl[i].ie;
         t_id = tbl[i].id;
         settle();
         chk($sformatf("vec%0d_reg_a", i), 0, 32'(ra[0]), 32'(tbl[i].e_ra));
         chk($sformatf("vec%0d_cc", i), 0, 32'(cco[0]), 32'(tbl[i].e_cc));
         chk($sformatf("vec%0d_branch", i), 0, 32'(be[0]), 32'(tbl[i].e_be));
         chk($sformatf("vec%0d_hazard", i), 0, 32'(hz[0]), 32'(tbl[i].e_hz));
         chk($sformatf("vec%0d_scoreboard", i), 0, 32'(sb0), 32'(tbl[i].e_sb));
         chk($sformatf("vec%0d_issue_err", i), 0, 32'(er[0]), 32'(tbl[i].e_err));
         edge_step();
      end

      // No-forwarding read and writeback-cycle hazard, from a freshly reset state.
      idle(); t_sa = 2; t_we = 1; t_wd = 2; t_wdata = 16'h1234;
      settle();
      chk("nobyp_same_cycle", 1, 32'(ra[1]), 32'h0000);
      chk("byp_same_cycle", 0, 32'(ra[0]), 32'h1234);
      edge_step();
      idle(); t_sa = 2;
      settle();
      chk("nobyp_next_cycle", 1, 32'(ra[1]), 32'h1234);
      edge_step();
      idle(); t_ie = 1; t_id = 6;
      settle();
      edge_step();
      idle(); t_sb = 6; t_rdb = 1;
      settle();
      chk("nobyp_wait", 1, 32'(hz[1]), 32'h1);
      edge_step();
      idle(); t_sb = 6; t_rdb = 1; t_we = 1; t_wd = 6; t_wdata = 16'h0001;
      settle();
      chk("nobyp_writeback", 1, 32'(hz[1]), 32'h1);
      chk("byp_writeback", 0, 32'(hz[0]), 32'h0);
      edge_step();
      idle(); t_sb = 6; t_rdb = 1;
      settle();
      chk("nobyp_after_wb", 1, 32'(hz[1]), 32'h0);
      edge_step();

      for (int n = 0; n < 1500; n++) begin
         t_rst_n = ($urandom_range(0, 39) != 0);
         t_sa    = 3'($urandom_range(0, 7));
         t_sb    = 3'($urandom_range(0, 7));
         t_rda   = 1'($urandom_range(0, 1));
         t_rdb   = 1'($urandom_range(0, 1));
         t_we    = 1'($urandom_range(0, 1));
         t_wd    = 3'($urandom_range(0, 7));
         t_wl    = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 3))
            0: t_wdata = 16'h0000;
            1: t_wdata = 16'h8000 | 16'($urandom_range(0, 16'hFFFF));
            default: t_wdata = 16'($urandom_range(0, 16'hFFFF));
         endcase
         t_lcc   = 1'($urandom_range(0, 1));
         t_br    = 3'($urandom_range(0, 7));
         t_ie    = ($urandom_range(0, 3) == 0);
         t_id    = 3'($urandom_range(0, 7));
         settle();
         edge_step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the SLC-3 register file, condition-code register and NZP comparator, merged into one unit.
- Register width, register count and link-register index are parameters.
- Adds a write-to-read bypass.
- Adds a per-register pending-write scoreboard, so the control FSM can issue multi-cycle memory loads and stall on RAW hazards.
- Sits between the CPU bus and the ALU/branch logic of the datapath.

Parameters:
- WIDTH, 16, data width of each register and of the bus.
- NREGS, 8, number of architectural registers (2..32). AW = $clog2(NREGS) is a derived localparam.
- LINK_REG, 7, register index written when wr_link=1 (JSR/TRAP return address).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding.

Ports:
- clk  in  1  clock; all state changes on posedge
- reset_n  in  1  synchronous active-low reset
- src_a  in  AW  read port A index
- src_b  in  AW  read port B index
- rd_a_en  in  1  port A operand is used this cycle (hazard qualification)
- rd_b_en  in  1  port B operand is used this cycle
- reg_a  out  WIDTH  port A data
- reg_b  out  WIDTH  port B data
- wr_en  in  1  write enable
- wr_dest  in  AW  write index
- wr_link  in  1  override write index with LINK_REG
- wr_data  in  WIDTH  write data (CPU bus)
- load_cc  in  1  update condition codes from wr_data
- cc  out  3  {n,z,p}
- br_nzp  in  3  branch mask, IR[11:9]
- branch_enable  out  1  |(br_nzp & cc)
- issue_en  in  1  mark a register as pending (load issued)
- issue_dest  in  AW  register to mark
- hazard  out  1  a used operand is pending
- scoreboard  out  NREGS  pending bit per register
- issue_err  out  1  sticky: issue to an already-pending register

Behaviour:
- Reset: when reset_n=0 at posedge, all registers become 0, cc becomes 3'b010, scoreboard becomes 0 and issue_err becomes 0. Reset overrides every other input in that cycle.
- Effective destination: dst = wr_link ? LINK_REG : wr_dest.
- Write: at posedge with wr_en=1 and dst < NREGS, reg[dst] <= wr_data and scoreboard[dst] <= 0, unless set by issue in the same cycle (see below).
- Read (combinational, 0 latency):
  - Index >= NREGS returns 0.
  - If BYPASS=1, wr_en=1 and dst == src, return wr_data.
  - Otherwise return the stored value.
- CC:
  - At posedge with load_cc=1, cc <= n if wr_data[WIDTH-1]=1, z if wr_data==0, else p.
  - Exactly one bit of cc is set at all times.
  - load_cc does not depend on wr_en.
- branch_enable: combinational from the registered cc only. CC updated in cycle t affects branch_enable from cycle t+1. br_nzp=000 always gives 0.
- Scoreboard:
  - At posedge with issue_en=1 and issue_dest < NREGS, scoreboard[issue_dest] <= 1.
  - Same-cycle write and issue to the same register: set wins (the older load retires, the newer one stays pending).
  - Issue to a register whose bit is 1 and is not being cleared in the same cycle: bit stays 1 and issue_err <= 1. issue_err is cleared only by reset.
- Busy and hazard:
  - busy_x = scoreboard[src_x] & ~(BYPASS & wr_en & dst==src_x).
  - hazard = (rd_a_en & busy_a) | (rd_b_en & busy_b).
  - With BYPASS=0, hazard stays 1 through the writeback cycle and drops the cycle after.
- Out-of-range indices (NREGS not a power of two): writes and issues are ignored; reads return 0 and are never busy.
- No other outputs are registered. reg_a, reg_b, hazard and branch_enable are combinational from state and inputs.

Test Plan:
1. Reset, then read all registers; cc=010, scoreboard=0; branch with br_nzp=010 -> branch_enable=1 the cycle after reset.
2. Write R3=16'h8001 with load_cc=1 -> cc=100 next cycle; br_nzp=011 gives branch_enable=0, br_nzp=100 gives 1. Write 0 -> cc=010; write 16'h0005 -> cc=001.
3. Bypass: with BYPASS=1, write R2=16'h1234 while src_a=2 -> reg_a=16'h1234 in the same cycle. With BYPASS=0, reg_a shows the old value until the next cycle.
4. Link write: wr_link=1, wr_dest=1, wr_data=16'h3001 -> R7=16'h3001, R1 unchanged.
5. Scoreboard:
   - Issue R4, then src_b=4 with rd_b_en=1 -> hazard=1 for each wait cycle.
   - Writeback R4 -> hazard=0 in the same cycle (BYPASS=1); scoreboard[4]=0 after.
   - With rd_b_en=0 -> hazard=0 throughout.
6. Simultaneous events:
   - Issue and write R5 in the same cycle -> scoreboard[5]=1, issue_err=0.
   - Issue R5 again with no write -> issue_err=1 and stays 1.
   - Drive reset_n=0 mid-pending -> everything cleared.
